// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus bundle for the multi-port register file.
//   master modport: read/write requester (drives addresses, enables, data, clr)
//   slave modport : register file (returns read data, rd_valid, init_busy)
//   ra        NUM_RD*ADDR_W  read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   re        1              read enable, common to all ports
//   rd        NUM_RD*DATA_W  registered read data, port i = rd[i*DATA_W +: DATA_W]
//   rd_valid  1              rd was updated by the previous edge
//   we/wa/wd                 write enable / address / data
//   clr       1              synchronous clear request (single-cycle pulse)
//   init_busy 1              clear sequence in progress
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic                     re;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     rd_valid;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     clr;
    logic                     init_busy;

    modport master (
        output ra, re, we, wa, wd, clr,
        input  rd, rd_valid, init_busy
    );

    modport slave (
        input  ra, re, we, wa, wd, clr,
        output rd, rd_valid, init_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: one-write / NUM_RD-read register file with registered read
// ports, optional hardwired zero entry, selectable read-during-write policy
// and a built-in sweep that zeroes every entry after reset or on clr.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  reg_file_mp_if.slave (ra, re, rd, rd_valid, we, wa, wd, clr, init_busy)
// The bus interface must be instantiated with the same DATA_W/ADDR_W/NUM_RD.
module reg_file_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int NUM_RD      = 2,
    parameter int ZERO_REG    = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_mp_if.slave   bus
);
    typedef enum logic {INIT, RUN} state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        cnt, cnt_nxt;
    logic [NUM_RD*DATA_W-1:0] rd_q, rd_nxt;
    logic                     rd_valid_q, rd_valid_nxt;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_wa;
    logic [DATA_W-1:0]        mem_wd;
    logic                     wr_ok;

    // A write only lands in RUN, with no clr pending, to an existing entry
    // that is not the hardwired zero register.
    assign wr_ok = (state == RUN) && !bus.clr && bus.we &&
                   ({1'b0, bus.wa} < DEPTH_V) &&
                   !((ZERO_REG != 0) && (bus.wa == '0));

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic              w_ok,
        input logic [ADDR_W-1:0] w_a,
        input logic [DATA_W-1:0] w_d
    );
        if ({1'b0, a} >= DEPTH_V)
            return '0;
        else if ((ZERO_REG != 0) && (a == '0))
            return '0;
        else if ((WRITE_FIRST != 0) && w_ok && (w_a == a))
            return w_d;
        else
            return mem[a];
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_nxt       = rd_q;
        rd_valid_nxt = 1'b0;
        mem_we       = 1'b0;
        mem_wa       = bus.wa;
        mem_wd       = bus.wd;

        unique case (state)
            INIT: begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = '0;
                rd_nxt = '0;
                if (bus.clr) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                if (bus.clr) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                    rd_nxt    = '0;
                end else begin
                    mem_we = wr_ok;
                    if (bus.re) begin
                        rd_valid_nxt = 1'b1;
                        for (int i = 0; i < NUM_RD; i++)
                            rd_nxt[i*DATA_W +: DATA_W] =
                                read_port(bus.ra[i*ADDR_W +: ADDR_W], wr_ok, bus.wa, bus.wd);
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rd_q       <= rd_nxt;
            rd_valid_q <= rd_valid_nxt;
        end
    end

    // NOTE: the storage array has no reset; the INIT sweep zeroes it, which
    // keeps the array free of a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    assign bus.rd        = rd_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.init_busy = (state == INIT);
endmodule
